rx_cmd_parser: RTL and testbench
================================

# rx_cmd_parser

Byte-level command parser sitting directly downstream of the UART receiver. It consumes each received byte (`p_data` qualified by `data_valid`) together with the frame error flags. It decodes multi-byte command frames into single-cycle register-file write/read and ALU-execute strobes for the system datapath. It aborts cleanly on framing/parity errors and flags malformed commands.

## Interface
Parameters:
- `DATA_W`, 8, received byte width; must match receiver frame width.
- `ADDR_W`, 4, register-file address width; taken from the low bits of the address byte.
- `FUN_W`, 4, ALU function width; taken from the low bits of the function byte.
- `TIMEOUT_W`, 16, width of the inter-byte timeout counter. Used only with `RX_CMD_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  reset. Asynchronous, active-low.
- `p_data`  in  DATA_W  received byte; valid only when `data_valid`=1.
- `data_valid`  in  1  one-cycle pulse per received byte.
- `parity_error`  in  1  receiver parity error flag.
- `stop_error`  in  1  receiver stop-bit error flag.
- `timeout_cyc`  in  TIMEOUT_W  inter-byte timeout limit in clk cycles. Ignored without the macro.
- `rf_wr_en`  out  1  register-file write strobe, one cycle.
- `rf_rd_en`  out  1  register-file read strobe, one cycle.
- `rf_addr`  out  ADDR_W  register-file address; holds between strobes.
- `rf_wr_data`  out  DATA_W  register-file write data; holds between strobes.
- `alu_en`  out  1  ALU execute strobe, one cycle.
- `alu_fun`  out  FUN_W  ALU function; holds between strobes.
- `busy`  out  1  high while a command is partially received (state ≠ IDLE).
- `cmd_err`  out  1  one-cycle pulse on any abort or unknown opcode.

## Operation
- Opcodes:
  - `0xAA` write: three bytes, opcode / addr / data.
  - `0xBB` read: two bytes, opcode / addr.
  - `0xCC` ALU with operands: four bytes, opcode / A / B / fun.
  - `0xDD` ALU without operands: two bytes, opcode / fun.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN. A state advances only on an accepted byte, i.e. `data_valid`=1 and both error flags = 0.
- IDLE:
  - `0xAA`→WR_ADDR, `0xBB`→RD_ADDR, `0xCC`→OP_A, `0xDD`→ALU_FUN.
  - Any other byte: `cmd_err` pulse, stay in IDLE.
- WR_ADDR: latch `rf_addr`=byte[ADDR_W-1:0], go to WR_DATA.
- WR_DATA: `rf_wr_data`=byte, pulse `rf_wr_en`, go to IDLE.
- RD_ADDR: `rf_addr`=byte[ADDR_W-1:0], pulse `rf_rd_en`, go to IDLE.
- OP_A: `rf_addr`=0, `rf_wr_data`=byte, pulse `rf_wr_en`, go to OP_B.
- OP_B: `rf_addr`=1, `rf_wr_data`=byte, pulse `rf_wr_en`, go to ALU_FUN.
- ALU_FUN: `alu_fun`=byte[FUN_W-1:0], pulse `alu_en`, go to IDLE.
- Address and function bytes are truncated to their low bits; upper bits are ignored and raise no error.
- Error handling:
  - `parity_error` or `stop_error` high in any cycle: byte discarded, `cmd_err` pulse. Any non-IDLE state goes to IDLE. In IDLE, stay.
  - Error wins over a simultaneous `data_valid`.
- No partial-command side effects are undone. For example, an OP_A write already issued stays issued.

## Timing
- All outputs are registered.
- Strobes (`rf_wr_en`, `rf_rd_en`, `alu_en`, `cmd_err`) assert exactly one cycle after the triggering `data_valid`/error cycle and last one cycle.
- Data outputs update in the same cycle as their strobe.
- At most one of `rf_wr_en` / `rf_rd_en` / `alu_en` is high in any cycle.
- Back-to-back `data_valid` on consecutive cycles is accepted. There is no backpressure; the parser never drops a valid byte.
- Reset (async assert, any state): state=IDLE; all outputs 0, including `rf_addr`, `rf_wr_data`, `alu_fun`, `busy`. A command in progress is lost.
- `busy` goes high the cycle after the opcode byte and low the cycle after the final byte or abort.

## Configuration
- `RX_CMD_TIMEOUT_EN` defined:
  - Counter clears on every accepted byte and counts while `busy`=1.
  - When it reaches `timeout_cyc`: `cmd_err` pulse, go to IDLE.
  - `timeout_cyc`=0 disables the timeout.
  - A byte arriving in the same cycle as expiry is accepted; the timeout is ignored.
- `RX_CMD_TIMEOUT_EN` undefined: no counter, `timeout_cyc` unused, partial commands wait indefinitely.

## Structure
- Package `rx_cmd_pkg`:
  - opcode constants `CMD_WR`, `CMD_RD`, `CMD_ALU_OP`, `CMD_ALU_NOP`;
  - state enum;
  - operand addresses `OPA_ADDR`=0, `OPB_ADDR`=1.
- Sub-module `rx_cmd_timer` (timeout counter with clear/enable/expire): instantiated only under `RX_CMD_TIMEOUT_EN`.
- FSM and output registers live in `rx_cmd_parser`.

## Test plan
- Bytes `AA,05,3C` → one `rf_wr_en` pulse with `rf_addr`=5, `rf_wr_data`=0x3C. No other strobes. `busy` falls after the pulse.
- Bytes `CC,12,34,02` → `rf_wr_en` with addr0/0x12, then `rf_wr_en` with addr1/0x34, then `alu_en` with `alu_fun`=2.
- Bytes `BB,07` → one `rf_rd_en` with `rf_addr`=7. Then `DD,03` → `alu_en` with `alu_fun`=3.
- Byte `AA`, then `parity_error` together with `data_valid`=1 and byte `05`:
  - required: `cmd_err` pulse, IDLE, no `rf_wr_en`;
  - a following `AA,01,FF` writes normally.
- Byte `5A` in IDLE → `cmd_err` pulse, no strobes. Async `rst` low after `CC,12` → all outputs 0 immediately; next `DD,01` yields `alu_en`.
- With `RX_CMD_TIMEOUT_EN`, `timeout_cyc`=100: `AA`, then idle for 100 cycles → `cmd_err` at expiry, `busy`=0. Without the macro: no `cmd_err`, `busy` stays 1.

Source files
------------

// File: rtl/rx_cmd_pkg.sv
// Shared definitions for the UART command parser.
//   - opcode byte values for the four command types
//   - parser FSM state encoding
//   - fixed register-file addresses used for the ALU operand writes
package rx_cmd_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;  // opcode / addr / data
  localparam logic [7:0] CMD_RD      = 8'hBB;  // opcode / addr
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // opcode / A / B / fun
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // opcode / fun

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_OP_A,
    ST_OP_B,
    ST_ALU_FUN
  } state_t;

endpackage

// File: rtl/rx_cmd_timer.sv
// Inter-byte timeout counter for the command parser.
// Only instantiated when RX_CMD_TIMEOUT_EN is defined.
//   clk, rst  : clock, asynchronous active-low reset
//   clr       : restart counting from zero (an accepted byte)
//   en        : count while high; held at zero while low
//   limit     : expiry count in clk cycles; zero disables expiry
//   expire    : high while the count has reached a non-zero limit
module rx_cmd_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (cnt != limit) begin
      // Stops at the limit so the count can never wrap past it.
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (limit != '0) && (cnt == limit);

endmodule

// File: rtl/rx_cmd_parser.sv
// Byte-level command parser placed after the UART receiver. Decodes
// multi-byte frames into register-file write/read and ALU execute strobes.
//   clk, rst                 : clock, asynchronous active-low reset
//   p_data, data_valid       : received byte and its one-cycle qualifier
//   parity_error, stop_error : receiver error flags; abort any command
//   timeout_cyc              : inter-byte timeout (RX_CMD_TIMEOUT_EN only)
//   rf_wr_en, rf_rd_en       : one-cycle register-file strobes
//   rf_addr, rf_wr_data      : register-file address / data, held
//   alu_en, alu_fun          : one-cycle ALU strobe and held function
//   busy                     : a command is partially received
//   cmd_err                  : one-cycle pulse on abort or unknown opcode
// Optional feature macro: RX_CMD_TIMEOUT_EN (inter-byte timeout abort).
module rx_cmd_parser
  import rx_cmd_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int FUN_W     = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    p_data,
  input  logic                 data_valid,
  input  logic                 parity_error,
  input  logic                 stop_error,
  input  logic [TIMEOUT_W-1:0] timeout_cyc,
  output logic                 rf_wr_en,
  output logic                 rf_rd_en,
  output logic [ADDR_W-1:0]    rf_addr,
  output logic [DATA_W-1:0]    rf_wr_data,
  output logic                 alu_en,
  output logic [FUN_W-1:0]     alu_fun,
  output logic                 busy,
  output logic                 cmd_err
);

  state_t              state_q, state_d;
  logic                wr_en_d, rd_en_d, alu_en_d, err_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [FUN_W-1:0]    fun_d;
  logic                frame_err;
  logic                accepted;
  logic                timeout_hit;

  assign frame_err = parity_error | stop_error;
  assign accepted  = data_valid & ~frame_err;

`ifdef RX_CMD_TIMEOUT_EN
  rx_cmd_timer #(
    .W (TIMEOUT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (accepted),
    .en     (state_q != ST_IDLE),
    .limit  (timeout_cyc),
    .expire (timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cyc;
  assign timeout_hit    = 1'b0;
`endif

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the value.
  always_comb begin
    state_d  = state_q;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    alu_en_d = 1'b0;
    err_d    = 1'b0;
    addr_d   = rf_addr;
    wdata_d  = rf_wr_data;
    fun_d    = alu_fun;

    if (frame_err) begin
      // A flagged byte is discarded even if data_valid is also high.
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else if (data_valid) begin
      // A byte landing on the expiry cycle takes priority over the timeout.
      unique case (state_q)
        ST_IDLE: begin
          case (p_data)
            DATA_W'(CMD_WR):      state_d = ST_WR_ADDR;
            DATA_W'(CMD_RD):      state_d = ST_RD_ADDR;
            DATA_W'(CMD_ALU_OP):  state_d = ST_OP_A;
            DATA_W'(CMD_ALU_NOP): state_d = ST_ALU_FUN;
            default:              err_d   = 1'b1;
          endcase
        end
        ST_WR_ADDR: begin
          addr_d  = p_data[ADDR_W-1:0];
          state_d = ST_WR_DATA;
        end
        ST_WR_DATA: begin
          wdata_d = p_data;
          wr_en_d = 1'b1;
          state_d = ST_IDLE;
        end
        ST_RD_ADDR: begin
          addr_d  = p_data[ADDR_W-1:0];
          rd_en_d = 1'b1;
          state_d = ST_IDLE;
        end
        ST_OP_A: begin
          addr_d  = ADDR_W'(OPA_ADDR);
          wdata_d = p_data;
          wr_en_d = 1'b1;
          state_d = ST_OP_B;
        end
        ST_OP_B: begin
          addr_d  = ADDR_W'(OPB_ADDR);
          wdata_d = p_data;
          wr_en_d = 1'b1;
          state_d = ST_ALU_FUN;
        end
        ST_ALU_FUN: begin
          fun_d    = p_data[FUN_W-1:0];
          alu_en_d = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      alu_en     <= 1'b0;
      cmd_err    <= 1'b0;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      alu_fun    <= '0;
    end else begin
      state_q    <= state_d;
      rf_wr_en   <= wr_en_d;
      rf_rd_en   <= rd_en_d;
      alu_en     <= alu_en_d;
      cmd_err    <= err_d;
      rf_addr    <= addr_d;
      rf_wr_data <= wdata_d;
      alu_fun    <= fun_d;
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Self-checking bench for rx_cmd_parser: a table of one-cycle byte vectors
// with hand-computed outputs, then hand-written reset and timeout sequences.
module tb_rx_cmd_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  p_data = '0;
  logic        data_valid = 1'b0;
  logic        parity_error = 1'b0;
  logic        stop_error = 1'b0;
  logic [15:0] timeout_cyc = 16'd100;
  logic        rf_wr_en, rf_rd_en, alu_en, busy, cmd_err;
  logic [3:0]  rf_addr, alu_fun;
  logic [7:0]  rf_wr_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rx_cmd_parser dut (
    .clk          (clk),
    .rst          (rst),
    .p_data       (p_data),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .stop_error   (stop_error),
    .timeout_cyc  (timeout_cyc),
    .rf_wr_en     (rf_wr_en),
    .rf_rd_en     (rf_rd_en),
    .rf_addr      (rf_addr),
    .rf_wr_data   (rf_wr_data),
    .alu_en       (alu_en),
    .alu_fun      (alu_fun),
    .busy         (busy),
    .cmd_err      (cmd_err)
  );

  // Output vector packing: {wr, rd, alu, err, busy, addr[3:0], wdata[7:0], fun[3:0]}
  typedef struct packed {
    logic       wr;
    logic       rd;
    logic       alu;
    logic       err;
    logic       busy;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [3:0] fun;
  } outs_t;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       perr;
    logic       serr;
    outs_t      exp;
  } vec_t;

  function automatic outs_t sample();
    outs_t o;
    o = '{wr: rf_wr_en, rd: rf_rd_en, alu: alu_en, err: cmd_err, busy: busy,
          addr: rf_addr, wdata: rf_wr_data, fun: alu_fun};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of input, then sample 1 time unit after the active edge.
  task automatic send(input logic v, input logic [7:0] d, input logic pe, input logic se);
    @(negedge clk);
    data_valid   = v;
    p_data       = d;
    parity_error = pe;
    stop_error   = se;
    @(posedge clk);
    #1;
  endtask

  function automatic outs_t mk(input logic wr, input logic rd, input logic alu,
                               input logic err, input logic bsy, input logic [3:0] a,
                               input logic [7:0] wd, input logic [3:0] f);
    outs_t o;
    o = '{wr: wr, rd: rd, alu: alu, err: err, busy: bsy, addr: a, wdata: wd, fun: f};
    return o;
  endfunction

  vec_t vecs[24];
  int   err_seen;

  initial begin
    //                 valid  data   pe    se     wr rd alu er by addr  wdata  fun
    vecs[0]  = '{1'b1, 8'hAA, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 4'h0, 8'h00, 4'h0)};
    vecs[1]  = '{1'b1, 8'h05, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 4'h5, 8'h00, 4'h0)};
    vecs[2]  = '{1'b1, 8'h3C, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 4'h5, 8'h3C, 4'h0)};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 4'h5, 8'h3C, 4'h0)};
    vecs[4]  = '{1'b1, 8'hCC, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 4'h5, 8'h3C, 4'h0)};
    vecs[5]  = '{1'b1, 8'h12, 1'b0, 1'b0, mk(1, 0, 0, 0, 1, 4'h0, 8'h12, 4'h0)};
    vecs[6]  = '{1'b1, 8'h34, 1'b0, 1'b0, mk(1, 0, 0, 0, 1, 4'h1, 8'h34, 4'h0)};
    vecs[7]  = '{1'b1, 8'h02, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 4'h1, 8'h34, 4'h2)};
    vecs[8]  = '{1'b1, 8'hBB, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 4'h1, 8'h34, 4'h2)};
    vecs[9]  = '{1'b1, 8'h07, 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 4'h7, 8'h34, 4'h2)};
    vecs[10] = '{1'b1, 8'hDD, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 4'h7, 8'h34, 4'h2)};
    vecs[11] = '{1'b1, 8'h03, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 4'h7, 8'h34, 4'h3)};
    vecs[12] = '{1'b1, 8'hAA, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 4'h7, 8'h34, 4'h3)};
    vecs[13] = '{1'b1, 8'h05, 1'b1, 1'b0, mk(0, 0, 0, 1, 0, 4'h7, 8'h34, 4'h3)};
    vecs[14] = '{1'b1, 8'hAA, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 4'h7, 8'h34, 4'h3)};
    vecs[15] = '{1'b1, 8'h01, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 4'h1, 8'h34, 4'h3)};
    vecs[16] = '{1'b1, 8'hFF, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 4'h1, 8'hFF, 4'h3)};
    vecs[17] = '{1'b1, 8'h5A, 1'b0, 1'b0, mk(0, 0, 0, 1, 0, 4'h1, 8'hFF, 4'h3)};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, mk(0, 0, 0, 1, 0, 4'h1, 8'hFF, 4'h3)};
    vecs[19] = '{1'b1, 8'hBB, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 4'h1, 8'hFF, 4'h3)};
    vecs[20] = '{1'b1, 8'hF9, 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 4'h9, 8'hFF, 4'h3)};
    vecs[21] = '{1'b1, 8'hDD, 1'b0, 1'b0, mk(0, 0, 0, 0, 1, 4'h9, 8'hFF, 4'h3)};
    vecs[22] = '{1'b1, 8'h7E, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 4'h9, 8'hFF, 4'hE)};
    vecs[23] = '{1'b1, 8'hAA, 1'b0, 1'b1, mk(0, 0, 0, 1, 0, 4'h9, 8'hFF, 4'hE)};

    // Reset state
    #12;
    check("reset_outputs", 32'(sample()), 32'(outs_t'('0)));
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].valid, vecs[i].data, vecs[i].perr, vecs[i].serr);
      check($sformatf("vec%0d", i), 32'(sample()), 32'(vecs[i].exp));
    end
    send(1'b0, 8'h00, 1'b0, 1'b0);
    check("idle_after_vecs", 32'(sample()), 32'(mk(0, 0, 0, 0, 0, 4'h9, 8'hFF, 4'hE)));

    // Asynchronous reset in the middle of an ALU-with-operands command
    send(1'b1, 8'hCC, 1'b0, 1'b0);
    send(1'b1, 8'h12, 1'b0, 1'b0);
    check("opa_before_reset", 32'(sample()), 32'(mk(1, 0, 0, 0, 1, 4'h0, 8'h12, 4'hE)));
    data_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_reset_clears", 32'(sample()), 32'(outs_t'('0)));
    @(negedge clk);
    rst = 1'b1;
    send(1'b1, 8'hDD, 1'b0, 1'b0);
    check("post_reset_opcode", 32'(sample()), 32'(mk(0, 0, 0, 0, 1, 4'h0, 8'h00, 4'h0)));
    send(1'b1, 8'h01, 1'b0, 1'b0);
    check("post_reset_alu", 32'(sample()), 32'(mk(0, 0, 1, 0, 0, 4'h0, 8'h00, 4'h1)));

    // Partial command left idle: times out only with the optional feature
    send(1'b1, 8'hAA, 1'b0, 1'b0);
    err_seen = 0;
    for (int c = 0; c < 120; c++) begin
      send(1'b0, 8'h00, 1'b0, 1'b0);
      if (cmd_err) err_seen++;
    end
`ifdef RX_CMD_TIMEOUT_EN
    check("timeout_err_pulses", 32'(err_seen), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
`else
    check("no_timeout_err", 32'(err_seen), 32'd0);
    check("no_timeout_busy", 32'(busy), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
